secuenciador_operaciones: RTL and testbench
===========================================

# secuenciador_operaciones

Sequences the 3-bit arithmetic/display datapath (sum, subtract, parity, compare, with its 4-way display multiplexer) automatically. On a start request it latches both operands and an operation mask, then drives the multiplexer select through each enabled operation, holding each one for a programmable dwell time. It sits between the board switches/buttons and the datapath: operands and select come from this block instead of directly from the switches.

## Interface
- `DWELL`, default 50_000_000, cycles each operation is displayed (≥1; 1 s at 50 MHz).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  level; begin a sequence when idle.
- `abort`  in  1  level; return to idle from any state.
- `pausa`  in  1  level; freeze the dwell counter and current select.
- `IN_A`, `IN_B`  in  3 each  operands from switches.
- `op_mask`  in  4  enable per op; bit i enables select code i.
- `A_Q`, `B_Q`  out  3 each  latched operands to datapath.
- `Selector`  out  2  mux select to datapath.
- `busy`  out  1  high while a sequence is running.
- `done`  out  1  one-cycle pulse at end of a pass.

## Operation
- Select codes: 0 sum, 1 subtract, 2 parity, 3 compare (mux inputs a..d).
- States: IDLE, SHOW, DONE.
- IDLE: `busy`=0. If `start`=1 and `abort`=0, on that edge capture `IN_A`, `IN_B`, `op_mask` into internal registers; `A_Q`/`B_Q` update; `Selector` ← lowest enabled code; dwell counter ← DWELL-1; go to SHOW. Mask all-zero: go directly to DONE; `Selector` unchanged.
- SHOW: `busy`=1. Each edge with `pausa`=0 decrements the counter. When counter=0 and `pausa`=0: if a higher enabled code exists, `Selector` ← next enabled code, counter reloads, stay in SHOW; otherwise go to DONE.
- DONE: `done`=1 for exactly one cycle, `busy`=0, then IDLE. `Selector`, `A_Q`, `B_Q` hold last values until the next start.
- `abort`=1 in any state: next edge → IDLE, no `done` pulse, outputs hold. `abort` beats `start` when simultaneous.
- `start` held high through DONE: a new sequence starts from the first IDLE cycle (level sensitive, back-to-back allowed).
- `IN_A`, `IN_B`, `op_mask` changes during SHOW are ignored.
- `pausa` in IDLE or DONE has no effect.

## Timing
- Reset: state IDLE, `Selector`=0, `A_Q`=`B_Q`=0, `busy`=0, `done`=0, counter=0.
- Start at edge k: `busy` high and first `Selector` valid from cycle k+1.
- Each enabled op is held exactly DWELL unpaused cycles. With N enabled ops, `done` asserts DWELL·N cycles after `busy` rises, then IDLE the cycle after.
- DWELL=1: `Selector` advances every cycle.
- Counter width is $clog2(DWELL) with a minimum of 1 bit. The counter never wraps below 0.
- Reset asserted mid-sequence: outputs go to reset values immediately (asynchronous).

## Configuration
- `SECUENCIADOR_LOOP_EN` defined: after the last enabled op, `Selector` wraps to the lowest enabled op and the counter reloads. `done` pulses one cycle at the wrap edge, `busy` stays 1, and the state stays SHOW until `abort`. An all-zero mask still goes to DONE.
- Not defined: the block runs a single pass and ends through DONE, as above.

## Structure
- Package `secuenciador_pkg`: state enum (IDLE, SHOW, DONE) and op code constants OP_SUMA=0, OP_RESTA=1, OP_PARIDAD=2, OP_COMP=3.
- Sub-module `busca_siguiente`: combinational. Inputs are the 4-bit mask and the current code; outputs are the next enabled code strictly above the current one, a found flag, and the lowest enabled code (used for start and wrap).

## Test plan
- DWELL=4, mask=1111, A=5, B=3, start pulse → `Selector` 0,1,2,3 each held 4 cycles; `A_Q`=5, `B_Q`=3; `done` 16 cycles after `busy` rises.
- Mask=1010 → `Selector` 1 then 3, 4 cycles each; `done` after 8 cycles.
- Mask=0000 with start → `done` on the cycle after start, `busy` never high.
- `pausa` held 3 cycles during op 2 → op 2 visible 7 cycles and `done` delayed 3 cycles. `abort` together with `start` in IDLE → stays IDLE.
- Mid-sequence `abort` → IDLE next cycle, no `done`. `rst_n` low during SHOW → all outputs 0 immediately.
- With `SECUENCIADOR_LOOP_EN`, mask=0011 → sequence 0,1,0,1…; `done` pulses at each wrap; `busy` stays 1 until `abort`.

Source files
------------

// File: rtl/secuenciador_pkg.sv
// ============================================================================
// Module   : secuenciador_pkg
// Brief    : Shared state encoding and datapath select codes for the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package secuenciador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    DONE = 2'd2
  } estado_t;

  localparam logic [1:0] OP_SUMA    = 2'd0;
  localparam logic [1:0] OP_RESTA   = 2'd1;
  localparam logic [1:0] OP_PARIDAD = 2'd2;
  localparam logic [1:0] OP_COMP    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/busca_siguiente.sv
// ============================================================================
// Module   : busca_siguiente
// Brief    : Finds the next enabled op code above the current one and the
//            lowest enabled op code in a 4-bit enable mask.
// Revision : 1.0
// ============================================================================
`default_nettype none

module busca_siguiente
  import secuenciador_pkg::*;
(
  input  logic [3:0] mask,
  input  logic [1:0] actual,
  output logic [1:0] siguiente,
  output logic       hallado,
  output logic [1:0] menor
);

  // Descending scan: the last hit written is the smallest qualifying code.
  always_comb begin
    siguiente = actual;
    hallado   = 1'b0;
    menor     = OP_SUMA;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) begin
        menor = 2'(i);
        if (2'(i) > actual) begin
          siguiente = 2'(i);
          hallado   = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/secuenciador_operaciones.sv
// ============================================================================
// Module   : secuenciador_operaciones
// Brief    : Steps the datapath display select through each enabled op,
//            holding each for DWELL cycles. SECUENCIADOR_LOOP_EN makes it
//            wrap continuously instead of ending after one pass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module secuenciador_operaciones
  import secuenciador_pkg::*;
#(
  parameter int DWELL = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       pausa,
  input  logic [2:0] IN_A,
  input  logic [2:0] IN_B,
  input  logic [3:0] op_mask,
  output logic [2:0] A_Q,
  output logic [2:0] B_Q,
  output logic [1:0] Selector,
  output logic       busy,
  output logic       done
);

  localparam int                 c_cnt_w  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(DWELL - 1);

  estado_t            r_state;
  estado_t            w_state_next;
  logic [2:0]         r_a;
  logic [2:0]         r_b;
  logic [3:0]         r_mask;
  logic [1:0]         r_sel;
  logic [c_cnt_w-1:0] r_cnt;
  logic [3:0]         w_mask_busca;
  logic [1:0]         w_siguiente;
  logic               w_hallado;
  logic [1:0]         w_menor;
  logic               w_arranque;
  logic               w_fin_op;
`ifdef SECUENCIADOR_LOOP_EN
  logic               r_wrap;
`endif

  // In IDLE the search looks at the live switches so the first code is ready at start.
  assign w_mask_busca = (r_state == IDLE) ? op_mask : r_mask;
  assign w_arranque   = (r_state == IDLE) && start && !abort;
  assign w_fin_op     = (r_state == SHOW) && !abort && !pausa && (r_cnt == '0);

  busca_siguiente u_busca (
    .mask      (w_mask_busca),
    .actual    (r_sel),
    .siguiente (w_siguiente),
    .hallado   (w_hallado),
    .menor     (w_menor)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_arranque) w_state_next = (op_mask == 4'b0000) ? DONE : SHOW;
      end
      SHOW: begin
        if (abort) begin
          w_state_next = IDLE;
        end else if (w_fin_op && !w_hallado) begin
`ifdef SECUENCIADOR_LOOP_EN
          w_state_next = SHOW;
`else
          w_state_next = DONE;
`endif
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_mask <= '0;
      r_sel  <= OP_SUMA;
      r_cnt  <= '0;
`ifdef SECUENCIADOR_LOOP_EN
      r_wrap <= 1'b0;
`endif
    end else begin
`ifdef SECUENCIADOR_LOOP_EN
      r_wrap <= 1'b0;
`endif
      if (w_arranque) begin
        r_a    <= IN_A;
        r_b    <= IN_B;
        r_mask <= op_mask;
        if (op_mask != 4'b0000) begin
          r_sel <= w_menor;
          r_cnt <= c_reload;
        end
      end else if (r_state == SHOW && !abort && !pausa) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else if (w_hallado) begin
          r_sel <= w_siguiente;
          r_cnt <= c_reload;
        end
`ifdef SECUENCIADOR_LOOP_EN
        else begin
          r_sel  <= w_menor;
          r_cnt  <= c_reload;
          r_wrap <= 1'b1;
        end
`endif
      end
    end
  end

  always_comb begin
    busy = (r_state == SHOW);
`ifdef SECUENCIADOR_LOOP_EN
    done = (r_state == DONE) || r_wrap;
`else
    done = (r_state == DONE);
`endif
  end

  assign A_Q      = r_a;
  assign B_Q      = r_b;
  assign Selector = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_secuenciador_operaciones.sv
// ============================================================================
// Module   : tb_secuenciador_operaciones
// Brief    : Self-checking bench for the op sequencer; honours
//            SECUENCIADOR_LOOP_EN when the design is built with it.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_secuenciador_operaciones;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pausa = 1'b0;
  logic [2:0] IN_A = '0;
  logic [2:0] IN_B = '0;
  logic [3:0] op_mask = '0;
  logic [2:0] A_Q;
  logic [2:0] B_Q;
  logic [1:0] Selector;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_err    = 0;

  // Expected visible state of the sequencer outputs
  logic [1:0] exp_sel = '0;
  logic [2:0] exp_a   = '0;
  logic [2:0] exp_b   = '0;

  secuenciador_operaciones #(.DWELL(DWELL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .pausa    (pausa),
    .IN_A     (IN_A),
    .IN_B     (IN_B),
    .op_mask  (op_mask),
    .A_Q      (A_Q),
    .B_Q      (B_Q),
    .Selector (Selector),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic busy_e, input logic done_e);
    chk({tag, ".sel"},  32'(Selector), 32'(exp_sel));
    chk({tag, ".a"},    32'(A_Q),      32'(exp_a));
    chk({tag, ".b"},    32'(B_Q),      32'(exp_b));
    chk({tag, ".busy"}, 32'(busy),     32'(busy_e));
    chk({tag, ".done"}, 32'(done),     32'(done_e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: the enabled codes in ascending order, each shown for DWELL
  // unpaused cycles, followed by the end-of-pass cycle.
  task automatic run_seq(input logic [2:0] a, input logic [2:0] b, input logic [3:0] m,
                         input bit rnd_pause, input int pz_op, input int pz_len);
    int ops[$];
    for (int i = 0; i < 4; i++) if (m[i]) ops.push_back(i);
    IN_A = a; IN_B = b; op_mask = m; start = 1'b1;
    step();
    start = 1'b0;
    IN_A = 3'($urandom); IN_B = 3'($urandom); op_mask = 4'($urandom);
    exp_a = a; exp_b = b;
    if (ops.size() == 0) begin
      chk_out("empty_done", 1'b0, 1'b1);
      step();
      chk_out("empty_idle", 1'b0, 1'b0);
      return;
    end
    foreach (ops[k]) begin
      int rem;
      int pz_left;
      rem = DWELL;
      pz_left = (ops[k] == pz_op) ? pz_len : 0;
      exp_sel = 2'(ops[k]);
      while (rem > 0) begin
        chk_out("show", 1'b1, 1'b0);
        if (pz_left > 0) begin
          pausa = 1'b1;
          pz_left--;
        end else if (rnd_pause) begin
          pausa = ($urandom_range(0, 3) == 0);
        end else begin
          pausa = 1'b0;
        end
        if (!pausa) rem--;
        step();
      end
    end
    pausa = 1'b0;
`ifdef SECUENCIADOR_LOOP_EN
    exp_sel = 2'(ops[0]);
    chk_out("wrap", 1'b1, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_out("loop_abort", 1'b0, 1'b0);
`else
    chk_out("done", 1'b0, 1'b1);
    step();
    chk_out("idle", 1'b0, 1'b0);
`endif
  endtask

  initial begin
    #1;
    chk_out("reset_hold", 1'b0, 1'b0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_out("reset_release", 1'b0, 1'b0);

    run_seq(3'd5, 3'd3, 4'b1111, 1'b0, -1, 0);
    run_seq(3'd2, 3'd7, 4'b1010, 1'b0, -1, 0);
    run_seq(3'd6, 3'd1, 4'b0000, 1'b0, -1, 0);
    run_seq(3'd4, 3'd4, 4'b1111, 1'b0, 2, 3);
    run_seq(3'd1, 3'd6, 4'b0011, 1'b0, -1, 0);

    // abort beats start in IDLE
    IN_A = 3'd7; IN_B = 3'd7; op_mask = 4'b1111; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk_out("abort_start", 1'b0, 1'b0);
    step();
    chk_out("abort_start2", 1'b0, 1'b0);

    // abort in the middle of a sequence
    IN_A = 3'd3; IN_B = 3'd2; op_mask = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    exp_a = 3'd3; exp_b = 3'd2; exp_sel = 2'd0;
    chk_out("mid_show", 1'b1, 1'b0);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_out("mid_abort", 1'b0, 1'b0);
    step();
    chk_out("mid_abort2", 1'b0, 1'b0);

`ifndef SECUENCIADOR_LOOP_EN
    // start held high: restart from the first IDLE cycle after DONE
    IN_A = 3'd1; IN_B = 3'd5; op_mask = 4'b0100; start = 1'b1;
    exp_a = 3'd1; exp_b = 3'd5; exp_sel = 2'd2;
    step();
    repeat (DWELL) begin
      chk_out("b2b_show", 1'b1, 1'b0);
      step();
    end
    chk_out("b2b_done", 1'b0, 1'b1);
    step();
    chk_out("b2b_idle", 1'b0, 1'b0);
    step();
    chk_out("b2b_restart", 1'b1, 1'b0);
    start = 1'b0;
    repeat (DWELL) step();
    chk_out("b2b_done2", 1'b0, 1'b1);
    step();
`endif

    repeat (10) begin
      run_seq(3'($urandom), 3'($urandom), 4'($urandom), 1'b1, -1, 0);
    end

    // asynchronous reset in the middle of SHOW
    IN_A = 3'd6; IN_B = 3'd5; op_mask = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    exp_a = '0; exp_b = '0; exp_sel = '0;
    chk_out("async_rst", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_out("after_rst", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
